// File: rtl/swlp_pkg.sv
// Shared types, constants and arithmetic helpers for the parametrised
// Shannon-Whitaker low-pass FIR (shannon_whitaker_lp_param).
package swlp_pkg;

  // Input-to-output latency of the filter pipeline, in clocks.
  localparam int LATENCY = 4;

  // Width used by the round/saturate helpers. It is wide enough for any
  // supported accumulator; callers sign-extend into it and truncate out of it.
  localparam int ACC_MAX_W = 64;
  localparam logic signed [ACC_MAX_W-1:0] ONE_W = 64'sd1;

  typedef enum logic [0:0] {
    LDR_LOAD   = 1'b0,
    LDR_COMMIT = 1'b1
  } ldr_state_e;

  // Full-precision accumulator width for NTAPS products of in x coef bits.
  function automatic int acc_width(input int in_bits, input int coef_bits, input int ntaps);
    return in_bits + coef_bits + $clog2(ntaps);
  endfunction

  // Round half up, then drop the fractional coefficient bits.
  function automatic logic signed [ACC_MAX_W-1:0] round_shift(
    input logic signed [ACC_MAX_W-1:0] acc, input int frac);
    logic signed [ACC_MAX_W-1:0] half;
    half = (frac > 0) ? (ONE_W <<< (frac - 1)) : '0;
    return (acc + half) >>> frac;
  endfunction

  function automatic logic signed [ACC_MAX_W-1:0] sat_hi(input int out_bits);
    return (ONE_W <<< (out_bits - 1)) - ONE_W;
  endfunction

  function automatic logic signed [ACC_MAX_W-1:0] sat_lo(input int out_bits);
    return -(ONE_W <<< (out_bits - 1));
  endfunction

  // Accumulator to output sample: round half up, then clip to out_bits signed.
  function automatic logic signed [ACC_MAX_W-1:0] round_sat(
    input logic signed [ACC_MAX_W-1:0] acc, input int frac, input int out_bits);
    logic signed [ACC_MAX_W-1:0] r;
    r = round_shift(acc, frac);
    if (r > sat_hi(out_bits))
      r = sat_hi(out_bits);
    else if (r < sat_lo(out_bits))
      r = sat_lo(out_bits);
    return r;
  endfunction

  // True when round_sat would clip this accumulator.
  function automatic logic sat_hit(
    input logic signed [ACC_MAX_W-1:0] acc, input int frac, input int out_bits);
    logic signed [ACC_MAX_W-1:0] r;
    r = round_shift(acc, frac);
    return (r > sat_hi(out_bits)) || (r < sat_lo(out_bits));
  endfunction

endpackage

// File: rtl/swlp_coef_loader.sv
// Coefficient loader: collects a framed stream of NTAPS coefficients into a
// shadow bank and swaps it into the active bank in a single clock.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   LDR_LOAD   | accepting beats into shadow[idx]; framing errors detected here
//   LDR_COMMIT | one clock, not ready; shadow copied to active bank at its end
module swlp_coef_loader
  import swlp_pkg::*;
#(
  parameter int NTAPS     = 15,
  parameter int COEF_BITS = 18,
  parameter int COEF_FRAC = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [COEF_BITS-1:0]        coef_dat_i,
  input  logic                        coef_valid_i,
  input  logic                        coef_last_i,
  output logic                        coef_ready_o,
  output logic                        coef_err_o,
  output logic                        coef_busy_o,
  output logic signed [COEF_BITS-1:0] coef_act_o [NTAPS]
);

  localparam int IDX_W  = $clog2(NTAPS);
  localparam int CENTER = (NTAPS - 1) / 2;
  localparam logic signed [COEF_BITS-1:0] COEF_ONE =
    {{(COEF_BITS-1){1'b0}}, 1'b1} << COEF_FRAC;

  ldr_state_e                  state_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        busy_q;
  logic                        err_q;
  logic signed [COEF_BITS-1:0] shadow_q [NTAPS];
  logic signed [COEF_BITS-1:0] act_q    [NTAPS];

  logic beat_acc;
  logic at_end;
  logic frame_bad;

  assign coef_ready_o = (state_q == LDR_LOAD);
  assign coef_err_o   = err_q;
  assign coef_busy_o  = busy_q;
  assign coef_act_o   = act_q;

  // A frame is bad when "last" and "final index" disagree: too short or too long.
  always_comb begin
    beat_acc  = coef_valid_i & coef_ready_o;
    at_end    = (idx_q == IDX_W'(NTAPS - 1));
    frame_bad = coef_last_i ^ at_end;
  end

  // Loader FSM, index counter, shadow bank and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LDR_LOAD;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < NTAPS; k++) shadow_q[k] <= '0;
    end else begin
      case (state_q)
        LDR_LOAD: begin
          if (beat_acc) begin
            if (frame_bad) begin
              err_q  <= 1'b1;
              idx_q  <= '0;
              busy_q <= 1'b0;
              for (int k = 0; k < NTAPS; k++) shadow_q[k] <= '0;
            end else begin
              shadow_q[idx_q] <= coef_dat_i;
              busy_q          <= 1'b1;
              if (at_end)
                state_q <= LDR_COMMIT;
              else
                idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        LDR_COMMIT: begin
          state_q <= LDR_LOAD;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= LDR_LOAD;
      endcase
    end
  end

  // Active bank: impulse out of reset, whole-bank swap at the end of COMMIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NTAPS; k++) act_q[k] <= (k == CENTER) ? COEF_ONE : '0;
    end else if (state_q == LDR_COMMIT) begin
      act_q <= shadow_q;
    end
  end

endmodule

// File: rtl/shannon_whitaker_lp_param.sv
// Parallel NSAMP-samples-per-clock FIR low-pass with runtime-loadable
// coefficients, fixed 4-clock latency, round-half-up and output saturation.
// Optional macro SWLP_SAT_COUNT_EN adds sat_cnt_o, a saturating count of
// clipped output samples.
module shannon_whitaker_lp_param
  import swlp_pkg::*;
#(
  parameter int NSAMP     = 8,
  parameter int NTAPS     = 15,
  parameter int IN_BITS   = 12,
  parameter int OUT_BITS  = 12,
  parameter int COEF_BITS = 18,
  parameter int COEF_FRAC = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NSAMP*IN_BITS-1:0]  dat_i,
  input  logic                      dat_valid_i,
  output logic [NSAMP*OUT_BITS-1:0] dat_o,
  output logic                      dat_valid_o,
  input  logic [COEF_BITS-1:0]      coef_dat_i,
  input  logic                      coef_valid_i,
  input  logic                      coef_last_i,
  output logic                      coef_ready_o,
  output logic                      coef_err_o,
  output logic                      coef_busy_o
`ifdef SWLP_SAT_COUNT_EN
  ,
  output logic [15:0]               sat_cnt_o
`endif
);

  localparam int NHIST  = NTAPS - 1;
  localparam int NWIN   = NSAMP + NHIST;
  localparam int PROD_W = IN_BITS + COEF_BITS;
  localparam int ACC_W  = acc_width(IN_BITS, COEF_BITS, NTAPS);
  localparam int NA     = NTAPS / 2;

  logic signed [COEF_BITS-1:0] coef_act [NTAPS];

  logic signed [IN_BITS-1:0]   hist_q   [NHIST];
  logic signed [IN_BITS-1:0]   win_d    [NWIN];
  logic signed [IN_BITS-1:0]   s1_win_q [NWIN];
  logic                        s1_vld_q;
  logic signed [PROD_W-1:0]    s2_prod_q [NSAMP][NTAPS];
  logic                        s2_vld_q;
  logic signed [ACC_W-1:0]     pa_d  [NSAMP];
  logic signed [ACC_W-1:0]     pb_d  [NSAMP];
  logic signed [ACC_W-1:0]     s3_pa_q [NSAMP];
  logic signed [ACC_W-1:0]     s3_pb_q [NSAMP];
  logic                        s3_vld_q;
  logic signed [ACC_W-1:0]     sum_d [NSAMP];
  logic [NSAMP*OUT_BITS-1:0]   dat_d;

  swlp_coef_loader #(
    .NTAPS     (NTAPS),
    .COEF_BITS (COEF_BITS),
    .COEF_FRAC (COEF_FRAC)
  ) u_loader (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .coef_dat_i   (coef_dat_i),
    .coef_valid_i (coef_valid_i),
    .coef_last_i  (coef_last_i),
    .coef_ready_o (coef_ready_o),
    .coef_err_o   (coef_err_o),
    .coef_busy_o  (coef_busy_o),
    .coef_act_o   (coef_act)
  );

  // Sample window: oldest history first, then the new beat (sample 0 oldest).
  always_comb begin
    for (int i = 0; i < NHIST; i++) win_d[i] = hist_q[i];
    for (int j = 0; j < NSAMP; j++) win_d[NHIST+j] = dat_i[j*IN_BITS +: IN_BITS];
  end

  // S1: capture the window every clock; history only moves on a valid beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NHIST; i++) hist_q[i] <= '0;
      for (int i = 0; i < NWIN; i++) s1_win_q[i] <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_win_q <= win_d;
      s1_vld_q <= dat_valid_i;
      if (dat_valid_i)
        for (int i = 0; i < NHIST; i++) hist_q[i] <= win_d[i+NSAMP];
    end
  end

  // S2: all products of a beat use one bank, so a swap never mixes banks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NSAMP; j++)
        for (int k = 0; k < NTAPS; k++) s2_prod_q[j][k] <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      for (int j = 0; j < NSAMP; j++)
        for (int k = 0; k < NTAPS; k++)
          s2_prod_q[j][k] <= PROD_W'(s1_win_q[NHIST+j-k]) * PROD_W'(coef_act[k]);
      s2_vld_q <= s1_vld_q;
    end
  end

  // Two partial sums per lane: lower taps and upper taps.
  always_comb begin
    for (int j = 0; j < NSAMP; j++) begin
      pa_d[j] = '0;
      pb_d[j] = '0;
      for (int k = 0; k < NTAPS; k++) begin
        if (k < NA)
          pa_d[j] = pa_d[j] + ACC_W'(s2_prod_q[j][k]);
        else
          pb_d[j] = pb_d[j] + ACC_W'(s2_prod_q[j][k]);
      end
    end
  end

  // S3: register partial sums.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NSAMP; j++) begin
        s3_pa_q[j] <= '0;
        s3_pb_q[j] <= '0;
      end
      s3_vld_q <= 1'b0;
    end else begin
      s3_pa_q  <= pa_d;
      s3_pb_q  <= pb_d;
      s3_vld_q <= s2_vld_q;
    end
  end

  // Final sum per lane, then round and clip into the output word.
  always_comb begin
    dat_d = '0;
    for (int j = 0; j < NSAMP; j++) begin
      sum_d[j] = s3_pa_q[j] + s3_pb_q[j];
      dat_d[j*OUT_BITS +: OUT_BITS] =
        OUT_BITS'(round_sat(ACC_MAX_W'(sum_d[j]), COEF_FRAC, OUT_BITS));
    end
  end

  // S4: output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dat_o       <= '0;
      dat_valid_o <= 1'b0;
    end else begin
      dat_o       <= dat_d;
      dat_valid_o <= s3_vld_q;
    end
  end

`ifdef SWLP_SAT_COUNT_EN
  logic [16:0] clip_n;
  logic [16:0] cnt_sum;

  // Clipped lanes in the beat being registered into S4, added to the count.
  always_comb begin
    clip_n = '0;
    for (int j = 0; j < NSAMP; j++)
      clip_n = clip_n + 17'(sat_hit(ACC_MAX_W'(sum_d[j]), COEF_FRAC, OUT_BITS));
    cnt_sum = {1'b0, sat_cnt_o} + clip_n;
  end

  // Saturation counter: only valid beats, sticks at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      sat_cnt_o <= '0;
    else if (s3_vld_q)
      sat_cnt_o <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule
